// File: rtl/pcihellocore_inport_edge.sv
// Avalon-MM input port: synchronizes and debounces an external bus, latches edges into a
// sticky write-1-to-clear capture register and raises a maskable level interrupt.
module pcihellocore_inport_edge #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned    CntW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] db_q, db_d, db_prev_q;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];

    logic             wr_en;
    logic [WIDTH-1:0] rise, fall, edge_ev, clear;
    logic             unused_writedata;

    assign wr_en            = chipselect & ~write_n;
    assign unused_writedata = ^writedata;

    // A bit must disagree with its debounced value for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    assign rise = db_q & ~db_prev_q;
    assign fall = ~db_q & db_prev_q;

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_ev = rise;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_ev = fall;
        end else begin : g_any
            assign edge_ev = rise | fall;
        end
    endgenerate

    // Set has priority over a simultaneous write-1-to-clear.
    assign clear     = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign edgecap_d = (edgecap_q & ~clear) | edge_ev;
    assign irqmask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= in_port;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = db_q;
            2'd2:    readdata[WIDTH-1:0] = irqmask_q;
            2'd3:    readdata[WIDTH-1:0] = edgecap_q;
            default: readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule
